// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the 5-stage pipeline datapath and its hazard controller.
// master = datapath side, slave = controller side.
interface pipeline_hazard_ctrl_if;
    logic [4:0]  rs1D, rs2D, rs1E, rs2E;
    logic [4:0]  rdE, rdM, rdW;
    logic        reg_wrE, reg_wrM, reg_wrW;
    logic [1:0]  wb_selE;
    logic        br_takenE;
    logic        dmem_reqM;
    logic        dmem_ready;
    logic        stallF, stallD, stallE, stallM;
    logic        flushD, flushE, flushW;
    logic [1:0]  fwdAE, fwdBE;
    logic        mem_wait;
    logic        mem_err;
    logic [31:0] stall_cnt, flush_cnt;

    modport master (
        output rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW,
        output reg_wrE, reg_wrM, reg_wrW, wb_selE, br_takenE, dmem_reqM, dmem_ready,
        input  stallF, stallD, stallE, stallM, flushD, flushE, flushW,
        input  fwdAE, fwdBE, mem_wait, mem_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW,
        input  reg_wrE, reg_wrM, reg_wrW, wb_selE, br_takenE, dmem_reqM, dmem_ready,
        output stallF, stallD, stallE, stallM, flushD, flushE, flushW,
        output fwdAE, fwdBE, mem_wait, mem_err, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage RV32I pipeline: load-use stalls,
// taken-branch flushes, data-memory wait with timeout, EX forwarding selects.
module pipeline_hazard_ctrl #(
    parameter int unsigned MAX_WAIT = 255,
    parameter logic [1:0]  LOAD_SEL = 2'b10
) (
    input logic                   clk,
    input logic                   rst,
    pipeline_hazard_ctrl_if.slave hz
);
    localparam int unsigned WAIT_W = 16;
    localparam int unsigned CNT_W  = 32;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    typedef enum logic {
        RUN   = 1'b0,
        MWAIT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic               mem_err_q, mem_err_d;
    logic               mem_wait_q, mem_wait_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

    logic memstall, lu, br_flush, stall_f_c;

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic       wr_m, input logic [4:0] rd_m,
                                           input logic       wr_w, input logic [4:0] rd_w);
        logic [1:0] sel;
        sel = 2'b00;
        if (wr_m && (rd_m != 5'd0) && (rd_m == rs))      sel = 2'b01;
        else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) sel = 2'b10;
        return sel;
    endfunction

    // Combinational stall/flush/forward decode; memory stall dominates, branch beats load-use.
    always_comb begin
        memstall  = hz.dmem_reqM & ~hz.dmem_ready;
        lu        = hz.reg_wrE & (hz.wb_selE == LOAD_SEL) & (hz.rdE != 5'd0)
                  & ((hz.rdE == hz.rs1D) | (hz.rdE == hz.rs2D));
        br_flush  = 1'b0;
        stall_f_c = 1'b0;
        hz.stallF = 1'b0;
        hz.stallD = 1'b0;
        hz.stallE = 1'b0;
        hz.stallM = 1'b0;
        hz.flushD = 1'b0;
        hz.flushE = 1'b0;
        hz.flushW = 1'b0;
        hz.fwdAE  = 2'b00;
        hz.fwdBE  = 2'b00;
        if (rst) begin
            hz.flushD = 1'b1;
            hz.flushE = 1'b1;
            hz.flushW = 1'b1;
        end else begin
            hz.fwdAE = fwd_sel(hz.rs1E, hz.reg_wrM, hz.rdM, hz.reg_wrW, hz.rdW);
            hz.fwdBE = fwd_sel(hz.rs2E, hz.reg_wrM, hz.rdM, hz.reg_wrW, hz.rdW);
            if (memstall) begin
                stall_f_c = 1'b1;
                hz.stallD = 1'b1;
                hz.stallE = 1'b1;
                hz.stallM = 1'b1;
                hz.flushW = 1'b1;
            end else begin
                br_flush  = hz.br_takenE;
                stall_f_c = lu & ~hz.br_takenE;
                hz.stallD = lu & ~hz.br_takenE;
                hz.flushD = hz.br_takenE;
                hz.flushE = hz.br_takenE | lu;
            end
            hz.stallF = stall_f_c;
        end
    end

    // Memory-wait FSM, timeout detection and performance counters.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        mem_err_d   = mem_err_q;
        stall_cnt_d = stall_cnt_q + CNT_W'(stall_f_c);
        flush_cnt_d = flush_cnt_q + CNT_W'(br_flush);
        case (state_q)
            RUN: begin
                wait_cnt_d = '0;
                if (memstall) state_d = MWAIT;
            end
            MWAIT: begin
                if (hz.dmem_ready) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else begin
                    // Counter parks at the limit so it can never wrap back under it.
                    if (wait_cnt_q < WAIT_LIMIT) wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    if (({1'b0, wait_cnt_q} + 17'd1) >= {1'b0, WAIT_LIMIT}) mem_err_d = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
        mem_wait_d = (state_d == MWAIT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            mem_err_q   <= 1'b0;
            mem_wait_q  <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_err_q   <= mem_err_d;
            mem_wait_q  <= mem_wait_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.mem_wait  = mem_wait_q;
    assign hz.mem_err   = mem_err_q;
    assign hz.stall_cnt = stall_cnt_q;
    assign hz.flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed hazard scenarios followed by
// randomized traffic, each cycle checked against a behavioural model.
module tb_pipeline_hazard_ctrl;
    localparam int unsigned MAX_WAIT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pipeline_hazard_ctrl_if hz();

    pipeline_hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .LOAD_SEL(2'b10)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
        logic       wrE, wrM, wrW;
        logic [1:0] wb_selE;
        logic       br, req, ready;
    } stim_t;

    typedef struct {
        logic [3:0]  stall;   // {F,D,E,M}
        logic [2:0]  flush;   // {D,E,W}
        logic [1:0]  fa, fb;
        logic        mw, me;
        logic [31:0] sc, fc;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    bit   stim_done = 1'b0;

    // Model state: waiting for memory, cycles waited, sticky error, counters.
    bit          m_wait = 1'b0;
    int          m_wcnt = 0;
    bit          m_err  = 1'b0;
    logic [31:0] m_sc   = '0;
    logic [31:0] m_fc   = '0;

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs, input stim_t s);
        if (rs == 5'd0) return 2'b00;
        if (s.wrM && s.rdM == rs) return 2'b01;
        if (s.wrW && s.rdW == rs) return 2'b10;
        return 2'b00;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '{rst: 1'b0, rs1D: 5'd0, rs2D: 5'd0, rs1E: 5'd0, rs2E: 5'd0, rdE: 5'd0,
              rdM: 5'd0, rdW: 5'd0, wrE: 1'b0, wrM: 1'b0, wrW: 1'b0, wb_selE: 2'b00,
              br: 1'b0, req: 1'b0, ready: 1'b0};
        return s;
    endfunction

    task automatic apply(input stim_t s);
        exp_t e;
        bit   ms, lu;
        @(posedge clk);
        #1;
        rst           = s.rst;
        hz.rs1D       = s.rs1D;
        hz.rs2D       = s.rs2D;
        hz.rs1E       = s.rs1E;
        hz.rs2E       = s.rs2E;
        hz.rdE        = s.rdE;
        hz.rdM        = s.rdM;
        hz.rdW        = s.rdW;
        hz.reg_wrE    = s.wrE;
        hz.reg_wrM    = s.wrM;
        hz.reg_wrW    = s.wrW;
        hz.wb_selE    = s.wb_selE;
        hz.br_takenE  = s.br;
        hz.dmem_reqM  = s.req;
        hz.dmem_ready = s.ready;
        ms = s.req && !s.ready;
        lu = s.wrE && s.wb_selE == 2'b10 && s.rdE != 5'd0 && (s.rdE == s.rs1D || s.rdE == s.rs2D);
        if (s.rst) begin
            e = '{stall: 4'b0000, flush: 3'b111, fa: 2'b00, fb: 2'b00, mw: 1'b0, me: 1'b0,
                  sc: 32'd0, fc: 32'd0};
            m_wait = 1'b0; m_wcnt = 0; m_err = 1'b0; m_sc = '0; m_fc = '0;
        end else begin
            e.mw = m_wait; e.me = m_err; e.sc = m_sc; e.fc = m_fc;
            e.fa = ref_fwd(s.rs1E, s);
            e.fb = ref_fwd(s.rs2E, s);
            if (ms) begin
                e.stall = 4'b1111;
                e.flush = 3'b001;
            end else begin
                e.stall = (lu && !s.br) ? 4'b1100 : 4'b0000;
                e.flush = {s.br, s.br || lu, 1'b0};
            end
            if (e.stall[3]) m_sc = m_sc + 32'd1;
            if (s.br && !ms) m_fc = m_fc + 32'd1;
            if (!m_wait) begin
                m_wait = ms;
                m_wcnt = 0;
            end else if (s.ready) begin
                m_wait = 1'b0;
                m_wcnt = 0;
            end else begin
                m_wcnt++;
                if (m_wcnt >= MAX_WAIT) m_err = 1'b1;
            end
        end
        sb_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, req);
        end
    endtask

    // Monitor: one scoreboard entry per cycle, sampled mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("stall", 32'({hz.stallF, hz.stallD, hz.stallE, hz.stallM}), 32'(e.stall));
                check("flush", 32'({hz.flushD, hz.flushE, hz.flushW}), 32'(e.flush));
                check("fwdAE", 32'(hz.fwdAE), 32'(e.fa));
                check("fwdBE", 32'(hz.fwdBE), 32'(e.fb));
                check("mem_wait", 32'(hz.mem_wait), 32'(e.mw));
                check("mem_err", 32'(hz.mem_err), 32'(e.me));
                check("stall_cnt", hz.stall_cnt, e.sc);
                check("flush_cnt", hz.flush_cnt, e.fc);
            end
        end
    end

    initial begin
        stim_t s;
        int    budget;
        s = idle(); s.rst = 1'b1;
        apply(s); apply(s);

        // Forwarding: M over W, W when rdM=0, none for x0.
        s = idle(); s.rdM = 5'd5; s.rdW = 5'd5; s.wrM = 1'b1; s.wrW = 1'b1; s.rs1E = 5'd5; s.rs2E = 5'd5;
        apply(s);
        s.rdM = 5'd0; apply(s);
        s.rs1E = 5'd0; apply(s);

        // Load-use single bubble, then branch + load-use together.
        s = idle(); s.wb_selE = 2'b10; s.rdE = 5'd7; s.rs2D = 5'd7; s.wrE = 1'b1;
        apply(s);
        apply(idle());
        s.br = 1'b1; apply(s);
        apply(idle());

        // Three-cycle memory wait with a concurrent taken branch, released on cycle 4.
        s = idle(); s.req = 1'b1; s.ready = 1'b0; s.br = 1'b1;
        repeat (3) apply(s);
        s.ready = 1'b1; apply(s);
        apply(idle());

        // Timeout: memory never answers, then answers late; error stays sticky.
        s = idle(); s.req = 1'b1; s.ready = 1'b0;
        repeat (7) apply(s);
        s.ready = 1'b1; apply(s);
        repeat (3) apply(idle());

        // Reset mid-wait with counters nonzero.
        s = idle(); s.br = 1'b1; apply(s);
        s = idle(); s.req = 1'b1; s.ready = 1'b0;
        repeat (2) apply(s);
        s.rst = 1'b1; apply(s);
        apply(idle());

        // Randomized traffic over a small register set to provoke hazards.
        for (int i = 0; i < 600; i++) begin
            s.rst     = ($urandom_range(0, 99) == 0);
            s.rs1D    = 5'($urandom_range(0, 3));
            s.rs2D    = 5'($urandom_range(0, 3));
            s.rs1E    = 5'($urandom_range(0, 3));
            s.rs2E    = 5'($urandom_range(0, 3));
            s.rdE     = 5'($urandom_range(0, 3));
            s.rdM     = 5'($urandom_range(0, 3));
            s.rdW     = 5'($urandom_range(0, 3));
            s.wrE     = 1'($urandom_range(0, 1));
            s.wrM     = 1'($urandom_range(0, 1));
            s.wrW     = 1'($urandom_range(0, 1));
            s.wb_selE = 2'($urandom_range(0, 3));
            s.br      = ($urandom_range(0, 3) == 0);
            s.req     = ($urandom_range(0, 9) < 4);
            s.ready   = ($urandom_range(0, 9) < 6);
            apply(s);
        end
        apply(idle());
        stim_done = 1'b1;

        budget = 0;
        while (sb_q.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        if (sb_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d entries left expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: stim_done=%0d expected 1", stim_done);
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end
endmodule
